model_div_seq: RTL and testbench

MODEL_DIV_SEQ -- requirements
Module: model_div_seq

---
 rtl/model_div_pkg.sv | 27 ++
 rtl/model_div_step.sv | 40 ++++
 rtl/model_div_seq.sv | 164 ++++++++++++++++
 tb/tb_model_div_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/model_div_pkg.sv
// -----------------------------------------------------------------------------
// model_div_pkg
// Shared definitions for the sequential divider:
//   - FSM state encoding (IDLE -> CALC -> FIX -> DONE)
//   - default operand width
//   - special-case result constants (all-ones, most-negative), held at the
//     widest supported width so the top can take its own WIDTH-sized slice.
// -----------------------------------------------------------------------------
package model_div_pkg;

    localparam int DIV_DEF_WIDTH = 32;
    localparam int DIV_MAX_WIDTH = 64;

    // Wide versions of the special-case constants. The divider takes the low
    // WIDTH bits of the all-ones pattern and the top WIDTH bits of the
    // most-negative pattern.
    localparam logic [DIV_MAX_WIDTH-1:0] DIV_ALL_ONES_MAX = {DIV_MAX_WIDTH{1'b1}};
    localparam logic [DIV_MAX_WIDTH-1:0] DIV_MOST_NEG_MAX = {1'b1, {(DIV_MAX_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/model_div_step.sv
// -----------------------------------------------------------------------------
// model_div_step
// One radix-2 restoring division iteration, purely combinational.
//   rem_in   [WIDTH:0]   partial remainder before the step
//   divisor  [WIDTH-1:0] divisor magnitude
//   quo_in   [WIDTH-1:0] quotient/dividend shift register; its MSB is the
//                        next dividend bit to bring down
//   rem_out  [WIDTH:0]   partial remainder after the step
//   quo_out  [WIDTH-1:0] shift register with the new quotient bit in the LSB
// -----------------------------------------------------------------------------
import model_div_pkg::*;

module model_div_step #(
    parameter int WIDTH = DIV_DEF_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic [WIDTH-1:0] quo_in,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] rem_sub;
    logic           keep;

    always_comb begin
        // Shift the next dividend bit into the partial remainder.
        rem_sh  = {rem_in[WIDTH-1:0], quo_in[WIDTH-1]};
        // A set top bit on the incoming remainder means the shifted value
        // exceeds any WIDTH-bit divisor, so the subtraction always succeeds.
        keep    = rem_in[WIDTH] || (rem_sh >= {1'b0, divisor});
        // The true difference is below the divisor, so modular WIDTH+1-bit
        // arithmetic is exact whenever keep is set.
        rem_sub = rem_sh - {1'b0, divisor};
        rem_out = keep ? rem_sub : rem_sh;
        quo_out = {quo_in[WIDTH-2:0], keep};
    end

endmodule

// File: rtl/model_div_seq.sv
// -----------------------------------------------------------------------------
// model_div_seq
// Multi-cycle radix-2 restoring divider with constant latency, supporting
// signed (DIV) and unsigned (DIVU) operation with defined divide-by-zero and
// signed-overflow results.
//   clk        clock, all state on posedge
//   reset_l    asynchronous active-low reset
//   start      request a divide (sampled only in IDLE)
//   abort      cancel an in-flight divide; wins over start
//   is_signed  1 = two's complement divide, 0 = unsigned
//   dividend   numerator, captured with start
//   divisor    denominator, captured with start
//   busy       high from the edge after start is accepted until done
//   done       one-cycle pulse; quotient/remainder valid
//   quotient   LO result (registered, changes only on FIX)
//   remainder  HI result (registered, changes only on FIX)
// Start accepted at edge N gives done high in the cycle after edge N+WIDTH+2.
// CNTW must satisfy 2**CNTW > WIDTH; WIDTH must not exceed DIV_MAX_WIDTH.
// -----------------------------------------------------------------------------
import model_div_pkg::*;

module model_div_seq #(
    parameter int WIDTH = DIV_DEF_WIDTH,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             start,
    input  logic             abort,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam logic [WIDTH-1:0] ALL_ONES = DIV_ALL_ONES_MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MOST_NEG = DIV_MOST_NEG_MAX[DIV_MAX_WIDTH-1 -: WIDTH];
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0]  LAST_CNT = CNTW'(WIDTH - 1);

    // Two's complement negate when neg is set.
    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                    input logic             neg);
        logic signed [WIDTH-1:0] val;
        val = signed'(mag);
        return neg ? WIDTH'(-val) : mag;
    endfunction

    // Magnitude of an operand; the most-negative value maps to 2^(WIDTH-1),
    // which is representable as an unsigned WIDTH-bit magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] val,
                                                   input logic             sgn);
        return apply_sign(val, sgn && val[WIDTH-1]);
    endfunction

    div_state_e       state, state_d;
    logic [CNTW-1:0]  cnt;
    logic             sgn_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] dvs_mag_q;
    logic [WIDTH:0]   rem_p0;
    logic [WIDTH-1:0] quo_p0;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] fix_quo;
    logic [WIDTH-1:0] fix_rem;
    logic             accept;
    logic             dvd_neg;
    logic             dvs_neg;

    assign accept = (state == ST_IDLE) && start && !abort;

    model_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_p0),
        .divisor (dvs_mag_q),
        .quo_in  (quo_p0),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // ---- FSM state register ----
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // ---- FSM next state ----
    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: if (accept) state_d = ST_CALC;
            ST_CALC: begin
                if (abort)                 state_d = ST_IDLE;
                else if (cnt == LAST_CNT)  state_d = ST_FIX;
            end
            ST_FIX:  state_d = abort ? ST_IDLE : ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---- Sign / special-case resolution of the magnitude results ----
    always_comb begin
        dvd_neg = sgn_q && dvd_q[WIDTH-1];
        dvs_neg = sgn_q && dvs_q[WIDTH-1];
        fix_quo = apply_sign(quo_p0, dvd_neg ^ dvs_neg);
        fix_rem = apply_sign(rem_p0[WIDTH-1:0], dvd_neg);
        if (dvs_q == '0) begin
            fix_quo = dvd_neg ? ONE : ALL_ONES;
            fix_rem = dvd_q;
        end else if (sgn_q && (dvd_q == MOST_NEG) && (dvs_q == ALL_ONES)) begin
            fix_quo = MOST_NEG;
            fix_rem = '0;
        end
    end

    // ---- Datapath and registered outputs ----
    // busy/done are registered one edge behind the state so busy rises on the
    // edge after acceptance and done lands one cycle after the DONE state.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            cnt       <= '0;
            sgn_q     <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            dvs_mag_q <= '0;
            rem_p0    <= '0;
            quo_p0    <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy <= ((state == ST_CALC) || (state == ST_FIX)) && !abort;
            done <= (state == ST_DONE) && !abort;
            if (accept) begin
                sgn_q     <= is_signed;
                dvd_q     <= dividend;
                dvs_q     <= divisor;
                dvs_mag_q <= magnitude(divisor, is_signed);
                quo_p0    <= magnitude(dividend, is_signed);
                rem_p0    <= '0;
                cnt       <= '0;
            end else if (state == ST_CALC && !abort) begin
                rem_p0 <= step_rem;
                quo_p0 <= step_quo;
                cnt    <= cnt + 1'b1;
            end else if (state == ST_FIX && !abort) begin
                quotient  <= fix_quo;
                remainder <= fix_rem;
            end
        end
    end

endmodule

// File: tb/tb_model_div_seq.sv
// -----------------------------------------------------------------------------
// tb_model_div_seq
// Directed self-checking bench for model_div_seq (WIDTH=32).
// -----------------------------------------------------------------------------
module tb_model_div_seq;

    logic        clk;
    logic        reset_l;
    logic        start;
    logic        abort;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_checks = 0;
    int n_errors = 0;

    model_div_seq #(
        .WIDTH (32),
        .CNTW  (6)
    ) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .start     (start),
        .abort     (abort),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a divide at the current cycle (called #1 after an edge), wait a
    // bounded number of edges for done, and check latency and results.
    task automatic run(input string tag, input logic sg, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
        int lat;
        lat       = -1;
        start     = 1'b1;
        is_signed = sg;
        dividend  = a;
        divisor   = b;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'd34);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        @(posedge clk); #1;
        check({tag, " done pulse width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic seen_done;
        reset_l   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #2;
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        reset_l = 1'b1;

        // Unsigned 100/7 with cycle-accurate busy/done, plus start ignored
        // while busy and while in DONE.
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        check("divu100 busy e0", {31'd0, busy}, 32'd0);
        for (int k = 1; k <= 35; k++) begin
            @(posedge clk); #1;
            if (k == 1)  check("divu100 busy e1", {31'd0, busy}, 32'd1);
            if (k == 5)  begin start = 1'b1; dividend = 32'd9; divisor = 32'd3; end
            if (k == 6)  start = 1'b0;
            if (k == 33) begin
                check("divu100 busy e33", {31'd0, busy}, 32'd1);
                check("divu100 done e33", {31'd0, done}, 32'd0);
                check("divu100 quotient", quotient, 32'd14);
                check("divu100 remainder", remainder, 32'd2);
                start = 1'b1;
            end
            if (k == 34) begin
                start = 1'b0;
                check("divu100 busy e34", {31'd0, busy}, 32'd0);
                check("divu100 done e34", {31'd0, done}, 32'd1);
            end
            if (k == 35) begin
                check("divu100 done e35", {31'd0, done}, 32'd0);
                check("start in DONE ignored busy", {31'd0, busy}, 32'd0);
            end
        end

        run("div -7/2",      1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run("div 7/-2",      1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run("div -100/-7",   1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE);
        run("divu 5/0",      1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5);
        run("div -5/0",      1'b1, 32'hFFFF_FFFB, 32'd0,         32'd1,         32'hFFFF_FFFB);
        run("div 5/0",       1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5);
        run("div ovf",       1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run("divu mneg",     1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
        run("div mneg/2",    1'b1, 32'h8000_0000, 32'd2,         32'hC000_0000, 32'd0);
        run("divu max/msb",  1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF);
        run("divu max/3",    1'b0, 32'hFFFF_FFFF, 32'd3,         32'h5555_5555, 32'd0);

        // Abort at edge 10: no done, outputs hold previous result.
        seen_done = 1'b0;
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen_done = 1'b1;
            if (k == 9)  abort = 1'b1;
            if (k == 10) begin
                abort = 1'b0;
                check("abort busy drop", {31'd0, busy}, 32'd0);
            end
        end
        check("abort no done", {31'd0, seen_done}, 32'd0);
        check("abort quotient hold", quotient, 32'h5555_5555);
        check("abort remainder hold", remainder, 32'd0);

        // Reset pulse around edge 20: outputs cleared, no done afterwards.
        seen_done = 1'b0;
        start = 1'b1; is_signed = 1'b1; dividend = 32'd1000; divisor = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk); #1;
        end
        #3 reset_l = 1'b0;
        @(posedge clk); #1;
        check("reset mid quotient", quotient, 32'd0);
        check("reset mid remainder", remainder, 32'd0);
        check("reset mid busy", {31'd0, busy}, 32'd0);
        reset_l = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("reset no done", {31'd0, seen_done}, 32'd0);
        check("reset busy idle", {31'd0, busy}, 32'd0);

        run("div after reset", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
